// File: rtl/sponge_absorber.sv
// sponge_absorber: message absorber that feeds a Permute block.
//
// Message lanes arrive over a valid/ready stream. Each lane is XORed into the rate part of
// the sponge state S. After every full rate block, S is handed to Permute with a one-cycle
// start pulse, and S is replaced by the Permute result on done. Once the block marked last
// has been permuted, S is presented downstream until it is acknowledged.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid/in_ready        lane stream handshake
//   in_data                  lane value (LANE_W bits)
//   in_last                  final-block marker, sampled only on lane RATE_LANES-1
//   perm_start               one-cycle start pulse to Permute
//   perm_data_in             state fed to Permute (registered S)
//   perm_done, perm_data_out Permute completion and result
//   state_valid, state_out   final state towards downstream
//   out_ack                  downstream has consumed state_out
//   blk_count                permuted-block counter (only when BLOCK_COUNT_EN is defined)
//
// Optional feature: define BLOCK_COUNT_EN to add the saturating 16-bit blk_count output.
// NUM_CELLS defaults to 1600.

module sponge_absorber #(
    parameter int unsigned NUM_CELLS  = 1600,
    parameter int unsigned LANE_W     = 64,
    parameter int unsigned RATE_LANES = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [LANE_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 perm_start,
    output logic [NUM_CELLS-1:0] perm_data_in,
    input  logic                 perm_done,
    input  logic [NUM_CELLS-1:0] perm_data_out,
    output logic                 state_valid,
    output logic [NUM_CELLS-1:0] state_out,
    input  logic                 out_ack
`ifdef BLOCK_COUNT_EN
    ,
    output logic [15:0]          blk_count
`endif
);

    localparam int unsigned CntW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CntW-1:0] LastLane = CntW'(RATE_LANES - 1);

    typedef enum logic [1:0] {
        StAccept,
        StFire,
        StWait,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_CELLS-1:0] s_q, s_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 last_q, last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StAccept;
            s_q     <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        in_ready    = 1'b0;
        perm_start  = 1'b0;
        state_valid = 1'b0;

        unique case (state_q)
            StAccept: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d[LANE_W*cnt_q +: LANE_W] = s_q[LANE_W*cnt_q +: LANE_W] ^ in_data;
                    if (cnt_q == LastLane) begin
                        // in_last only matters on the closing lane of a block
                        cnt_d   = '0;
                        last_d  = in_last;
                        state_d = StFire;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFire: begin
                // Decoded from the state register so reset removes the pulse immediately
                perm_start = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                if (perm_done) begin
                    s_d     = perm_data_out;
                    state_d = last_q ? StDone : StAccept;
                end
            end
            StDone: begin
                state_valid = 1'b1;
                if (out_ack) begin
                    s_d     = '0;
                    last_d  = 1'b0;
                    state_d = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase
    end

    // S only changes on an accepted lane, on done in WAIT, or on ack in DONE, so it is
    // stable for Permute from FIRE through the end of WAIT.
    assign perm_data_in = s_q;
    assign state_out    = state_valid ? s_q : '0;

`ifdef BLOCK_COUNT_EN
    logic [15:0] blk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_q <= '0;
        end else if (state_q == StDone && out_ack) begin
            blk_q <= '0;
        end else if (state_q == StFire && blk_q != 16'hFFFF) begin
            blk_q <= blk_q + 16'd1;
        end
    end

    assign blk_count = blk_q;
`endif

endmodule

// File: tb/tb_sponge_absorber.sv
// Testbench for sponge_absorber with a Permute stub (done three cycles after start is
// sampled, data_out = ~data_in). A lane-array model tracks the sponge state and queues the
// expected Permute inputs and final states; a monitor compares every cycle.

module tb_sponge_absorber;

    localparam int NC = 1600;
    localparam int LW = 64;
    localparam int RL = 17;
    localparam int NL = NC / LW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic [LW-1:0] in_data   = '0;
    logic          in_last   = 1'b0;
    logic          out_ack   = 1'b0;
    logic          perm_done = 1'b0;
    logic          in_ready;
    logic          perm_start;
    logic          state_valid;
    logic [NC-1:0] perm_data_in;
    logic [NC-1:0] perm_data_out;
    logic [NC-1:0] state_out;
    logic [NC-1:0] stub_cap = '0;
    int            stub_cd  = 0;
`ifdef BLOCK_COUNT_EN
    logic [15:0]   blk_count;
`endif

    sponge_absorber #(
        .NUM_CELLS (NC),
        .LANE_W    (LW),
        .RATE_LANES(RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .perm_start   (perm_start),
        .perm_data_in (perm_data_in),
        .perm_done    (perm_done),
        .perm_data_out(perm_data_out),
        .state_valid  (state_valid),
        .state_out    (state_out),
        .out_ack      (out_ack)
`ifdef BLOCK_COUNT_EN
        ,
        .blk_count    (blk_count)
`endif
    );

    always #5 clk = ~clk;

    // Permute stub: not tied to rst, so a reset in WAIT leaves a stray done behind
    always @(posedge clk) begin
        perm_done <= 1'b0;
        if (perm_start) begin
            stub_cap <= perm_data_in;
            stub_cd  <= 3;
        end else if (stub_cd != 0) begin
            stub_cd <= stub_cd - 1;
            if (stub_cd == 1) perm_done <= 1'b1;
        end
    end
    assign perm_data_out = ~stub_cap;

    // Model
    logic [LW-1:0] m_s [NL];
    int            m_cnt = 0;
    logic [NC-1:0] exp_perm  [$];
    logic [NC-1:0] exp_final [$];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [NC-1:0] pack_model();
        logic [NC-1:0] p;
        for (int i = 0; i < NL; i++) p[LW*i +: LW] = m_s[i];
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_s[i] = '0;
        m_cnt = 0;
        exp_perm.delete();
        exp_final.delete();
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < NL; i++) begin
                if (act[LW*i +: LW] !== exp[LW*i +: LW]) begin
                    $display("FAIL %s: lane %0d got %h, expected %h (t=%0t)", nm, i,
                             act[LW*i +: LW], exp[LW*i +: LW], $time);
                    break;
                end
            end
        end
    endtask

    task automatic monitor();
        logic prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (perm_start) begin
                    chk64("perm_start single-cycle", 64'(prev_start), 64'd0);
                    if (exp_perm.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL perm_start: got 1, expected 0 (no block pending)");
                    end else begin
                        chkw("perm_data_in", perm_data_in, exp_perm.pop_front());
                    end
                end
                if (state_valid) begin
                    if (exp_final.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL state_valid: got 1, expected 0 (no final pending)");
                    end else begin
                        chkw("state_out", state_out, exp_final[0]);
                    end
                end
                if (perm_start || state_valid) chk64("in_ready while busy", 64'(in_ready), 64'd0);
                prev_start = perm_start;
            end else begin
                prev_start = 1'b0;
            end
        end
    endtask

    // All stimulus tasks start and end just after a falling edge
    task automatic send_lane(input logic [LW-1:0] d, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL lane handshake: in_ready stayed 0 for %0d cycles, expected 1", k);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m_s[m_cnt] = m_s[m_cnt] ^ d;
        if (m_cnt == RL - 1) begin
            exp_perm.push_back(pack_model());
            for (int i = 0; i < NL; i++) m_s[i] = ~m_s[i];
            if (l) exp_final.push_back(pack_model());
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input logic [LW-1:0] base, input logic [LW-1:0] step,
                              input bit last, input bit gap, input int stray_last);
        for (int i = 0; i < RL; i++) begin
            send_lane(base + step * LW'(i), (i == stray_last) || (last && i == RL - 1));
            if (gap && i != RL - 1) @(negedge clk);
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!state_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!state_valid) begin
            n_vec++;
            n_fail++;
            $display("FAIL state_valid wait: got 0 after %0d cycles, expected 1", k);
        end
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        @(posedge clk);
        if (exp_final.size() != 0) void'(exp_final.pop_front());
        for (int i = 0; i < NL; i++) m_s[i] = '0;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        model_clear();
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        chk64("reset in_ready", 64'(in_ready), 64'd1);
        chk64("reset perm_start", 64'(perm_start), 64'd0);
        chk64("reset state_valid", 64'(state_valid), 64'd0);
        chkw("reset state_out", state_out, '0);
        rst = 1'b1;
        @(negedge clk);

        // Single block of 64'h1, last
        send_block(64'h1, 64'h0, 1'b1, 1'b0, -1);
        wait_valid();
        chk64("single lane0", state_out[0 +: 64], ~64'h1);
        chk64("single lane16", state_out[64*16 +: 64], ~64'h1);
        chk64("single lane17", state_out[64*17 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
        chk64("single lane24", state_out[64*24 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef BLOCK_COUNT_EN
        chk64("single blk_count", 64'(blk_count), 64'd1);
`endif
        repeat (3) @(negedge clk);
        do_ack();
        chk64("after ack state_valid", 64'(state_valid), 64'd0);
        chk64("after ack in_ready", 64'(in_ready), 64'd1);

        // Two blocks of 64'hA5; a stray in_last on lane 3 of the first must be ignored
        send_block(64'hA5, 64'h0, 1'b0, 1'b0, 3);
        send_block(64'hA5, 64'h0, 1'b1, 1'b0, -1);
        wait_valid();
        chkw("two-block final", state_out, '0);
`ifdef BLOCK_COUNT_EN
        chk64("two-block blk_count", 64'(blk_count), 64'd2);
`endif
        do_ack();
`ifdef BLOCK_COUNT_EN
        chk64("blk_count cleared", 64'(blk_count), 64'd0);
`endif

        // Backpressure: valid on every other cycle
        send_block(64'h100, 64'h1, 1'b0, 1'b1, -1);
        k = 0;
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk64("in_ready low window", 64'(k), 64'd5);
        send_block(64'h3C00, 64'h11, 1'b1, 1'b1, -1);
        wait_valid();
        do_ack();

        // Reset during WAIT
        send_block(64'h1, 64'h0, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk64("mid-reset in_ready", 64'(in_ready), 64'd1);
        chk64("mid-reset perm_start", 64'(perm_start), 64'd0);
        chkw("mid-reset state_out", state_out, '0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk64("post-reset in_ready", 64'(in_ready), 64'd1);
            chk64("post-reset state_valid", 64'(state_valid), 64'd0);
        end
        send_block(64'h1, 64'h0, 1'b1, 1'b0, -1);
        wait_valid();
        chk64("post-reset lane0", state_out[0 +: 64], ~64'h1);
        chk64("post-reset lane20", state_out[64*20 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
        do_ack();

        // in_valid held through DONE
        send_block(64'h7, 64'h3, 1'b1, 1'b0, -1);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        in_last  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk64("DONE in_ready", 64'(in_ready), 64'd0);
        end
        do_ack();
        send_lane(64'h1234, 1'b0);
        for (int i = 1; i < RL; i++) send_lane(64'h0, i == RL - 1);
        wait_valid();
        chk64("after-ack lane0", state_out[0 +: 64], ~64'h1234);
        chk64("after-ack lane1", state_out[64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
        do_ack();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
